// File: rtl/pkt_dmux_nport.sv
// rtl/pkt_dmux_nport.sv - N-port packet demux with PTP classification, drop/abort handling and statistics
//
// Classifies each packet on its 2nd word (Ethernet header) and replicates every word to a
// destination bitmap of NUM_PORTS outputs, two cycles after acceptance.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_data_wr/in_data  input word strobe and word; [DW-1:DW-2] 01 head, 11 body, 10 tail
//   in_data_valid(_wr)  upstream packet-good flag/strobe (unused, regenerated here)
//   in_ready            ~|out_alf, checked by upstream before a head
//   out_data_wr         per-port word strobe
//   out_data            shared output word
//   out_data_valid(_wr) end-of-packet good flag and per-port strobe
//   out_alf             per-port almost-full
//   device_mac/role     local MAC, [1]=switch role, [0]=master
//   cfg_nonptp_map      destination bitmap for non-PTP traffic
//   rx_pkt_cnt/drop_cnt/err_cnt  saturating statistics
module pkt_dmux_nport #(
    parameter int          NUM_PORTS  = 4,
    parameter int          DW         = 134,
    parameter int          LOCAL_PORT = 0,
    parameter int          FWD_PORT   = 1,
    parameter logic [15:0] PTP_ETYPE  = 16'h88F7,
    parameter int          CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_data_wr,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_data_valid,
    input  logic                 in_data_valid_wr,
    output logic                 in_ready,
    output logic [NUM_PORTS-1:0] out_data_wr,
    output logic [DW-1:0]        out_data,
    output logic                 out_data_valid,
    output logic [NUM_PORTS-1:0] out_data_valid_wr,
    input  logic [NUM_PORTS-1:0] out_alf,
    input  logic [47:0]          device_mac,
    input  logic [1:0]           device_role,
    input  logic [NUM_PORTS-1:0] cfg_nonptp_map,
    output logic [CNT_W-1:0]     rx_pkt_cnt,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam logic [1:0]           TAG_HEAD   = 2'b01;
    localparam logic [1:0]           TAG_TAIL   = 2'b10;
    localparam logic [47:0]          BCAST      = 48'hFFFF_FFFF_FFFF;
    localparam logic [NUM_PORTS-1:0] LOCAL_MASK = {{(NUM_PORTS-1){1'b0}}, 1'b1} << LOCAL_PORT;
    localparam logic [NUM_PORTS-1:0] FWD_MASK   = {{(NUM_PORTS-1){1'b0}}, 1'b1} << FWD_PORT;
    localparam logic [CNT_W-1:0]     CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_FWD, S_DROP} state_t;

    state_t                 state;
    logic [NUM_PORTS-1:0]   bitmap;
    logic                   p1_vld;
    logic                   p1_tail;
    logic [DW-1:0]          p1_data;

    logic [1:0]             in_tag;
    logic                   is_head;
    logic                   is_tail;
    logic                   head_ok;
    logic                   hdr_fail;
    logic [NUM_PORTS-1:0]   bm_c;
    logic [NUM_PORTS-1:0]   bm_eff;
    logic [47:0]            w_dst;
    logic [15:0]            w_etype;
    logic [15:0]            w_msg;

    // Upstream packet-good qualification is regenerated locally.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, in_data_valid, in_data_valid_wr};

    assign in_ready = ~|out_alf;
    assign in_tag   = in_data[DW-1:DW-2];
    assign is_head  = in_data_wr && (in_tag == TAG_HEAD);
    assign is_tail  = in_data_wr && (in_tag == TAG_TAIL);
    assign head_ok  = is_head && in_ready;
    assign w_dst    = in_data[127:80];
    assign w_etype  = in_data[31:16];
    assign w_msg    = in_data[15:0];

    // Destination bitmap from the Ethernet-header word currently on the input.
    always_comb begin
        bm_c = '0;
        if (w_etype != PTP_ETYPE) begin
            bm_c = cfg_nonptp_map;
        end else if (device_role[1]) begin
            if ((w_dst == device_mac) && ((w_msg == 16'h0301) || (w_msg == 16'h0401)))
                bm_c = LOCAL_MASK;
            else if (w_dst == BCAST)
                bm_c = device_role[0] ? '0 : (LOCAL_MASK | FWD_MASK);
            else
                bm_c = FWD_MASK;
        end else if ((w_dst == device_mac) || (w_dst == BCAST)) begin
            bm_c = LOCAL_MASK;
        end
    end

    // While the head sits in stage 1 the bitmap register is not yet loaded, so the
    // head is steered by the header word arriving in the same cycle.
    assign bm_eff   = (state == S_HDR) ? bm_c : bitmap;
    assign hdr_fail = (state == S_HDR) && !in_data_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            bitmap            <= '0;
            p1_vld            <= 1'b0;
            p1_tail           <= 1'b0;
            p1_data           <= '0;
            out_data_wr       <= '0;
            out_data          <= '0;
            out_data_valid    <= 1'b0;
            out_data_valid_wr <= '0;
            rx_pkt_cnt        <= '0;
            drop_cnt          <= '0;
            err_cnt           <= '0;
        end else begin
            out_data_wr       <= '0;
            out_data_valid_wr <= '0;
            out_data_valid    <= 1'b0;
            p1_vld            <= 1'b0;

            // Output stage: emit the stage-1 word unless it is a head whose header never came.
            if (p1_vld && !hdr_fail) begin
                out_data    <= p1_data;
                out_data_wr <= bm_eff;
                if (p1_tail) begin
                    out_data_valid_wr <= bm_eff;
                    out_data_valid    <= 1'b1;
                end
            end

            // A head cutting into a packet closes the old one as aborted on the next output.
            if (((state == S_FWD) || (state == S_DROP)) && head_ok) begin
                out_data_valid_wr <= bitmap;
                out_data_valid    <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (head_ok) begin
                        p1_vld  <= 1'b1;
                        p1_tail <= 1'b0;
                        p1_data <= in_data;
                        state   <= S_HDR;
                        if (~&rx_pkt_cnt) rx_pkt_cnt <= rx_pkt_cnt + CNT_ONE;
                    end else if (in_data_wr && !is_head) begin
                        if (~&err_cnt) err_cnt <= err_cnt + CNT_ONE;
                    end
                end
                S_HDR: begin
                    if (in_data_wr) begin
                        bitmap <= bm_c;
                        if (bm_c == '0) begin
                            if (~&drop_cnt) drop_cnt <= drop_cnt + CNT_ONE;
                            state <= is_tail ? S_IDLE : S_DROP;
                        end else begin
                            p1_vld  <= 1'b1;
                            p1_tail <= is_tail;
                            p1_data <= in_data;
                            state   <= is_tail ? S_IDLE : S_FWD;
                        end
                    end else begin
                        if (~&err_cnt) err_cnt <= err_cnt + CNT_ONE;
                        state <= S_IDLE;
                    end
                end
                S_FWD, S_DROP: begin
                    if (head_ok) begin
                        p1_vld  <= 1'b1;
                        p1_tail <= 1'b0;
                        p1_data <= in_data;
                        state   <= S_HDR;
                        if (~&rx_pkt_cnt) rx_pkt_cnt <= rx_pkt_cnt + CNT_ONE;
                        if (~&err_cnt) err_cnt <= err_cnt + CNT_ONE;
                    end else if (in_data_wr && !is_head) begin
                        if (state == S_FWD) begin
                            p1_vld  <= 1'b1;
                            p1_tail <= is_tail;
                            p1_data <= in_data;
                        end
                        if (is_tail) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_dmux_nport.sv
// tb/tb_pkt_dmux_nport.sv - directed self-checking bench for pkt_dmux_nport
module tb_pkt_dmux_nport;

    localparam int DW = 134;
    localparam logic [47:0] MAC   = 48'h0011_2233_4455;
    localparam logic [47:0] OTHER = 48'h0A0B_0C0D_0E0F;
    localparam logic [47:0] BC    = 48'hFFFF_FFFF_FFFF;
    localparam logic [1:0]  T_BODY = 2'b11;
    localparam logic [1:0]  T_TAIL = 2'b10;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_data_wr;
    logic [DW-1:0]  in_data;
    logic           in_data_valid;
    logic           in_data_valid_wr;
    logic           in_ready;
    logic [3:0]     out_data_wr;
    logic [DW-1:0]  out_data;
    logic           out_data_valid;
    logic [3:0]     out_data_valid_wr;
    logic [3:0]     out_alf;
    logic [47:0]    device_mac;
    logic [1:0]     device_role;
    logic [3:0]     cfg_nonptp_map;
    logic [31:0]    rx_pkt_cnt;
    logic [31:0]    drop_cnt;
    logic [31:0]    err_cnt;

    int checks = 0;
    int passed = 0;
    logic [DW-1:0] hist0 = '0;
    logic [DW-1:0] hist1 = '0;

    pkt_dmux_nport dut (
        .clk               (clk),
        .rst               (rst),
        .in_data_wr        (in_data_wr),
        .in_data           (in_data),
        .in_data_valid     (in_data_valid),
        .in_data_valid_wr  (in_data_valid_wr),
        .in_ready          (in_ready),
        .out_data_wr       (out_data_wr),
        .out_data          (out_data),
        .out_data_valid    (out_data_valid),
        .out_data_valid_wr (out_data_valid_wr),
        .out_alf           (out_alf),
        .device_mac        (device_mac),
        .device_role       (device_role),
        .cfg_nonptp_map    (cfg_nonptp_map),
        .rx_pkt_cnt        (rx_pkt_cnt),
        .drop_cnt          (drop_cnt),
        .err_cnt           (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] head(input logic [31:0] n);
        return {2'b01, 100'h0, n};
    endfunction
    function automatic logic [DW-1:0] body(input logic [31:0] n);
        return {2'b11, 100'h0, n};
    endfunction
    function automatic logic [DW-1:0] tail(input logic [31:0] n);
        return {2'b10, 100'h0, n};
    endfunction
    function automatic logic [DW-1:0] eth(input logic [1:0] tag, input logic [47:0] dst,
                                          input logic [15:0] et, input logic [15:0] msg);
        return {tag, 4'h0, dst, 48'hAABB_CCDD_EEFF, et, msg};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One clock step: check the outputs now visible (word driven two steps ago), then drive this step's input.
    task automatic cyc(input string tag, input logic wr, input logic [DW-1:0] d,
                       input logic [3:0] ewr, input logic [3:0] evwr, input logic ev);
        @(negedge clk);
        chk({tag, ".wr"}, DW'(out_data_wr), DW'(ewr));
        chk({tag, ".vwr"}, DW'(out_data_valid_wr), DW'(evwr));
        if (evwr != 4'b0) chk({tag, ".valid"}, DW'(out_data_valid), DW'(ev));
        if (ewr != 4'b0) chk({tag, ".data"}, out_data, hist1);
        hist1 = hist0;
        hist0 = d;
        in_data_wr = wr;
        in_data    = d;
    endtask

    initial begin
        rst = 1'b1;
        in_data_wr = 1'b0;
        in_data = '0;
        in_data_valid = 1'b0;
        in_data_valid_wr = 1'b0;
        out_alf = 4'b0;
        device_mac = MAC;
        device_role = 2'b10;
        cfg_nonptp_map = 4'b0100;
        repeat (2) @(negedge clk);
        chk("rst.wr", DW'(out_data_wr), '0);
        chk("rst.vwr", DW'(out_data_valid_wr), '0);
        chk("rst.rx", DW'(rx_pkt_cnt), '0);
        chk("rst.drop", DW'(drop_cnt), '0);
        chk("rst.err", DW'(err_cnt), '0);
        rst = 1'b0;

        // Non-PTP 4-word packet to map 0100
        cyc("t1c0", 1, head(1), 4'b0000, 4'b0000, 0);
        cyc("t1c1", 1, eth(T_BODY, OTHER, 16'h0800, 16'h0), 4'b0000, 4'b0000, 0);
        cyc("t1c2", 1, body(3), 4'b0100, 4'b0000, 0);
        cyc("t1c3", 1, tail(4), 4'b0100, 4'b0000, 0);
        cyc("t1c4", 0, '0, 4'b0100, 4'b0000, 0);
        cyc("t1c5", 0, '0, 4'b0100, 4'b0100, 1);
        cyc("t1c6", 0, '0, 4'b0000, 4'b0000, 0);
        chk("t1.rx", DW'(rx_pkt_cnt), DW'(1));

        // PTP broadcast, slave switch -> LOCAL|FWD
        cyc("t2c0", 1, head(5), 4'b0000, 4'b0000, 0);
        cyc("t2c1", 1, eth(T_BODY, BC, 16'h88F7, 16'h0B01), 4'b0000, 4'b0000, 0);
        cyc("t2c2", 1, tail(6), 4'b0011, 4'b0000, 0);
        cyc("t2c3", 0, '0, 4'b0011, 4'b0000, 0);
        cyc("t2c4", 0, '0, 4'b0011, 4'b0011, 1);
        // Same packet, master switch -> dropped
        device_role = 2'b11;
        cyc("t2d0", 1, head(5), 4'b0000, 4'b0000, 0);
        cyc("t2d1", 1, eth(T_BODY, BC, 16'h88F7, 16'h0B01), 4'b0000, 4'b0000, 0);
        cyc("t2d2", 1, tail(6), 4'b0000, 4'b0000, 0);
        cyc("t2d3", 0, '0, 4'b0000, 4'b0000, 0);
        cyc("t2d4", 0, '0, 4'b0000, 4'b0000, 0);
        chk("t2.drop", DW'(drop_cnt), DW'(1));
        device_role = 2'b10;

        // Unicast to this device: 0x0301 -> LOCAL, 0x0B01 -> FWD (2-word packets)
        cyc("t3a0", 1, head(7), 4'b0000, 4'b0000, 0);
        cyc("t3a1", 1, eth(T_TAIL, MAC, 16'h88F7, 16'h0301), 4'b0000, 4'b0000, 0);
        cyc("t3a2", 0, '0, 4'b0001, 4'b0000, 0);
        cyc("t3a3", 0, '0, 4'b0001, 4'b0001, 1);
        cyc("t3b0", 1, head(8), 4'b0000, 4'b0000, 0);
        cyc("t3b1", 1, eth(T_TAIL, MAC, 16'h88F7, 16'h0B01), 4'b0000, 4'b0000, 0);
        cyc("t3b2", 0, '0, 4'b0010, 4'b0000, 0);
        cyc("t3b3", 0, '0, 4'b0010, 4'b0010, 1);

        // Back-to-back: non-PTP then PTP broadcast, head right after tail
        cyc("t4c0", 1, head(9), 4'b0000, 4'b0000, 0);
        cyc("t4c1", 1, eth(T_BODY, OTHER, 16'h0800, 16'h0), 4'b0000, 4'b0000, 0);
        cyc("t4c2", 1, tail(10), 4'b0100, 4'b0000, 0);
        cyc("t4c3", 1, head(11), 4'b0100, 4'b0000, 0);
        cyc("t4c4", 1, eth(T_BODY, BC, 16'h88F7, 16'h0B01), 4'b0100, 4'b0100, 1);
        cyc("t4c5", 1, tail(12), 4'b0011, 4'b0000, 0);
        cyc("t4c6", 0, '0, 4'b0011, 4'b0000, 0);
        cyc("t4c7", 0, '0, 4'b0011, 4'b0011, 1);
        cyc("t4c8", 0, '0, 4'b0000, 4'b0000, 0);

        // Head after two body words without tail -> abort, then new packet to LOCAL
        cyc("t5c0", 1, head(13), 4'b0000, 4'b0000, 0);
        cyc("t5c1", 1, eth(T_BODY, OTHER, 16'h0800, 16'h0), 4'b0000, 4'b0000, 0);
        cyc("t5c2", 1, body(15), 4'b0100, 4'b0000, 0);
        cyc("t5c3", 1, body(16), 4'b0100, 4'b0000, 0);
        cyc("t5c4", 1, head(17), 4'b0100, 4'b0000, 0);
        cyc("t5c5", 1, eth(T_BODY, MAC, 16'h88F7, 16'h0301), 4'b0100, 4'b0100, 0);
        cyc("t5c6", 1, tail(19), 4'b0001, 4'b0000, 0);
        cyc("t5c7", 0, '0, 4'b0001, 4'b0000, 0);
        cyc("t5c8", 0, '0, 4'b0001, 4'b0001, 1);
        chk("t5.err", DW'(err_cnt), DW'(1));
        chk("t5.rx", DW'(rx_pkt_cnt), DW'(9));

        // Head with no 2nd word -> discarded, error
        cyc("gap0", 1, head(20), 4'b0000, 4'b0000, 0);
        cyc("gap1", 0, '0, 4'b0000, 4'b0000, 0);
        cyc("gap2", 0, '0, 4'b0000, 4'b0000, 0);
        cyc("gap3", 0, '0, 4'b0000, 4'b0000, 0);
        chk("gap.err", DW'(err_cnt), DW'(2));
        // Body word while idle -> ignored, error
        cyc("idl0", 1, body(21), 4'b0000, 4'b0000, 0);
        cyc("idl1", 0, '0, 4'b0000, 4'b0000, 0);
        cyc("idl2", 0, '0, 4'b0000, 4'b0000, 0);
        chk("idl.err", DW'(err_cnt), DW'(3));
        chk("idl.rx", DW'(rx_pkt_cnt), DW'(10));

        // Back-pressure: head ignored while in_ready=0
        out_alf = 4'b0100;
        #1 chk("t6.rdy0", DW'(in_ready), DW'(0));
        cyc("t6a0", 1, head(22), 4'b0000, 4'b0000, 0);
        cyc("t6a1", 0, '0, 4'b0000, 4'b0000, 0);
        cyc("t6a2", 0, '0, 4'b0000, 4'b0000, 0);
        cyc("t6a3", 0, '0, 4'b0000, 4'b0000, 0);
        chk("t6.rx_hold", DW'(rx_pkt_cnt), DW'(10));
        chk("t6.err_hold", DW'(err_cnt), DW'(3));
        out_alf = 4'b0000;
        #1 chk("t6.rdy1", DW'(in_ready), DW'(1));
        cyc("t6b0", 1, head(22), 4'b0000, 4'b0000, 0);
        cyc("t6b1", 1, eth(T_TAIL, OTHER, 16'h0800, 16'h0), 4'b0000, 4'b0000, 0);
        cyc("t6b2", 0, '0, 4'b0100, 4'b0000, 0);
        cyc("t6b3", 0, '0, 4'b0100, 4'b0100, 1);
        chk("t6.rx", DW'(rx_pkt_cnt), DW'(11));

        // Reset mid-packet flushes the pipeline
        cyc("t6c0", 1, head(24), 4'b0000, 4'b0000, 0);
        cyc("t6c1", 1, eth(T_BODY, OTHER, 16'h0800, 16'h0), 4'b0000, 4'b0000, 0);
        cyc("t6c2", 1, body(26), 4'b0100, 4'b0000, 0);
        rst = 1'b1;
        cyc("t6c3", 0, '0, 4'b0000, 4'b0000, 0);
        rst = 1'b0;
        cyc("t6c4", 0, '0, 4'b0000, 4'b0000, 0);
        cyc("t6c5", 0, '0, 4'b0000, 4'b0000, 0);
        chk("t6.rst_rx", DW'(rx_pkt_cnt), '0);
        chk("t6.rst_err", DW'(err_cnt), '0);
        chk("t6.rst_drop", DW'(drop_cnt), '0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
